divider_seq: RTL and testbench
==============================

Name: divider_seq

Overview:
- Sequential restoring unsigned divider. It is the inverse arithmetic partner of the team's combinational ripple adder.
- It recovers quotient and remainder from an NUM_BITS-wide dividend and divisor, one quotient bit per clock.
- It sits behind a start/done handshake so a control FSM can launch a division and collect the results.
- The datapath re-uses a combinational subtract-with-borrow stage, which mirrors the adder's carry chain.

Parameters:
NUM_BITS, 4, operand, quotient and remainder width (legal range 2..16)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset, sampled on rising edge of clk
start  input  1  request a division; sampled only in IDLE
dividend  input  NUM_BITS  unsigned dividend, sampled with start
divisor  input  NUM_BITS  unsigned divisor, sampled with start
busy  output  1  high while a division is in progress (CALC state)
done  output  1  one-cycle pulse: results valid
quotient  output  NUM_BITS  registered quotient
remainder  output  NUM_BITS  registered remainder
div_by_zero  output  1  registered flag, set when divisor was 0

Behaviour:
- Reset: one clock and one synchronous active-high reset, rst, on clk.
  - rst high at an edge forces state IDLE, with busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
  - Internal shift registers and iteration counter are cleared.
  - rst has priority over every other input, including mid-CALC; an in-flight division is abandoned with no done pulse.
- State IDLE:
  - start=1 at edge E0 with divisor!=0:
    - latch dividend into quotient shift register Q and divisor into register D;
    - clear partial remainder R (NUM_BITS+1 bits) and counter;
    - go to CALC.
  - start=1 at E0 with divisor==0:
    - go to DONE;
    - load quotient = all ones, remainder = dividend, div_by_zero=1.
- State CALC: one iteration per edge, exactly NUM_BITS edges (E1..E_NUM_BITS).
  - {R,Q} shifted left by 1.
  - trial = R_shifted - {0,D}, computed in NUM_BITS+1 bits with borrow.
  - If borrow=0: R <= trial and Q[0] <= 1. Otherwise R is kept and Q[0] <= 0.
  - The counter increments each edge. On the last iteration go to DONE, register quotient=Q and remainder=R[NUM_BITS-1:0], and set div_by_zero=0.
- State DONE:
  - done=1 for exactly one cycle, then unconditionally go to IDLE.
  - start is ignored in DONE.
- Latency: done high in the cycle after edge E_NUM_BITS, i.e. NUM_BITS cycles after the start edge. For divide-by-zero, done is high in the cycle after E0.
- busy=1 exactly in CALC.
- start while busy or in DONE is ignored, with no queuing. Operand changes after E0 have no effect.
- quotient, remainder and div_by_zero hold their values from DONE until the next DONE or rst.
- Back-to-back: start may be asserted in the cycle done is high, but it is sampled only at the following edge, once in IDLE. Minimum issue interval is NUM_BITS+2 cycles.
- Arithmetic is unsigned only. Invariant when div_by_zero=0: dividend == quotient*divisor + remainder, with remainder < divisor.

Decomposition:
- Package divider_pkg:
  - state enum {IDLE, CALC, DONE} (2-bit);
  - DIV_DEFAULT_BITS=4;
  - counter width function $clog2(NUM_BITS+1).
- Sub-module sub_nbit:
  - combinational (NUM_BITS+1)-bit subtract-with-borrow;
  - ports a, b, diff, borrow_out;
  - it is the subtractive counterpart of the ripple adder.
- The FSM and shift registers stay in divider_seq.

Test Plan:
- rst for 2 cycles, then idle: busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
- dividend=13, divisor=3, start pulse at E0: busy=1 for 4 cycles, done=1 in the cycle after E4, quotient=4, remainder=1, div_by_zero=0.
- dividend=9, divisor=0: done in the cycle after E0, quotient=15, remainder=9, div_by_zero=1.
- Start 5/7, then at E2 assert start with 15/1 and raise rst at E3: no done pulse, all outputs 0 after E3. A fresh 15/1 then gives quotient=15, remainder=0.
- Start 14/4 and hold start high through CALC: exactly one done pulse, quotient=3, remainder=2. The next division starts only after returning to IDLE.
- Exhaustive sweep of all 256 dividend/divisor pairs (NUM_BITS=4), one start per completion: check the invariant, or the divide-by-zero outputs. Report the count of passing cases in a final block.

Source files
------------

// File: rtl/divider_pkg.sv
// divider_pkg: shared types and helpers for the sequential restoring divider.
//   div_state_e     : controller states (IDLE, CALC, DONE)
//   DIV_DEFAULT_BITS: default operand width
//   div_cnt_width() : width of the iteration counter for a given operand width
package divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

    localparam int DIV_DEFAULT_BITS = 4;

    // The counter must be able to represent 0..num_bits.
    function automatic int div_cnt_width(input int num_bits);
        return $clog2(num_bits + 1);
    endfunction

endpackage

// File: rtl/sub_nbit.sv
// sub_nbit: combinational WIDTH-bit subtract-with-borrow, the subtractive
// counterpart of the ripple adder.
//   a          : minuend
//   b          : subtrahend
//   diff       : a - b modulo 2^WIDTH
//   borrow_out : 1 when b > a
module sub_nbit #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    // One extra bit on both operands; its value after subtraction is the borrow.
    assign {borrow_out, diff} = {1'b0, a} - {1'b0, b};

endmodule

// File: rtl/divider_seq.sv
// divider_seq: sequential restoring unsigned divider, one quotient bit per clock,
// behind a start/done handshake.
//   clk, rst    : clock and synchronous active-high reset
//   start       : launch a division (sampled only in IDLE)
//   dividend    : unsigned dividend, captured with start
//   divisor     : unsigned divisor, captured with start
//   busy        : high while iterating (CALC)
//   done        : one-cycle pulse when results are valid
//   quotient    : registered quotient
//   remainder   : registered remainder
//   div_by_zero : registered flag, divisor was zero
//
// state | meaning
// IDLE  | waiting for start
// CALC  | shifting/subtracting, one quotient bit per edge
// DONE  | results valid, done pulse, back to IDLE next edge
module divider_seq
    import divider_pkg::*;
#(
    parameter int NUM_BITS = DIV_DEFAULT_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [NUM_BITS-1:0] dividend,
    input  logic [NUM_BITS-1:0] divisor,
    output logic                busy,
    output logic                done,
    output logic [NUM_BITS-1:0] quotient,
    output logic [NUM_BITS-1:0] remainder,
    output logic                div_by_zero
);

    localparam int CNT_W = div_cnt_width(NUM_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_BITS - 1);

    div_state_e          state_q, state_d;
    logic [NUM_BITS:0]   r_q, r_d;
    logic [NUM_BITS-1:0] q_q, q_d;
    logic [NUM_BITS-1:0] d_q, d_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_BITS-1:0] quot_q, quot_d;
    logic [NUM_BITS-1:0] rem_q, rem_d;
    logic                dbz_q, dbz_d;

    logic [NUM_BITS:0]   r_shift;
    logic [NUM_BITS:0]   trial;
    logic                borrow;
    logic [NUM_BITS:0]   r_next;
    logic [NUM_BITS-1:0] q_next;
    logic                unused_r_msb;

    // R is always below D before a shift, so its top bit is never set;
    // the extra bit only matters after the shift, where it feeds the subtractor.
    assign r_shift      = {r_q[NUM_BITS-1:0], q_q[NUM_BITS-1]};
    assign unused_r_msb = r_q[NUM_BITS];

    sub_nbit #(
        .WIDTH(NUM_BITS + 1)
    ) u_sub (
        .a         (r_shift),
        .b         ({1'b0, d_q}),
        .diff      (trial),
        .borrow_out(borrow)
    );

    // Restoring step: keep the shifted remainder when the trial borrows.
    assign r_next = borrow ? r_shift : trial;
    assign q_next = {q_q[NUM_BITS-2:0], ~borrow};

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (divisor != '0) begin
                        q_d     = dividend;
                        d_d     = divisor;
                        r_d     = '0;
                        cnt_d   = '0;
                        state_d = CALC;
                    end else begin
                        quot_d  = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            CALC: begin
                r_d   = r_next;
                q_d   = q_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    quot_d  = q_next;
                    rem_d   = r_next[NUM_BITS-1:0];
                    dbz_d   = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q == CALC);
    assign done        = (state_q == DONE);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider_seq.sv
module tb_divider_seq;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    int total = 0;
    int bad   = 0;
    int sweep_pass = 0;
    int done_pulses = 0;

    divider_seq #(.NUM_BITS(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_pulses++;

    typedef struct {
        int a;
        int b;
        int q;
        int r;
        int dbz;
        int lat;
        int busy_cycles;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Launch at the next edge (E0), then count edges until done is seen.
    // lat = edges after E0 before done shows; busy_n = cycles with busy high.
    task automatic run_div(input int a, input int b,
                           output int lat, output int busy_n, output int ok);
        @(negedge clk);
        start    = 1'b1;
        dividend = N'(a);
        divisor  = N'(b);
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        lat = 0;
        busy_n = 0;
        ok = 1;
        while (done !== 1'b1) begin
            if (busy === 1'b1) busy_n++;
            if (lat > 40) begin
                ok = 0;
                break;
            end
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL timeout: no done for %0d/%0d", a, b);
        end
    endtask

    initial begin
        int lat, bn, ok, dp;

        vecs[0] = '{13, 3,  4, 1, 0, 4, 4};
        vecs[1] = '{9,  0, 15, 9, 1, 0, 0};
        vecs[2] = '{14, 4,  3, 2, 0, 4, 4};
        vecs[3] = '{15, 1, 15, 0, 0, 4, 4};
        vecs[4] = '{0,  5,  0, 0, 0, 4, 4};
        vecs[5] = '{15, 15, 1, 0, 0, 4, 4};
        vecs[6] = '{7,  8,  0, 7, 0, 4, 4};
        vecs[7] = '{15, 0, 15, 15, 1, 0, 0};

        rst = 1'b1;
        start = 1'b0;
        dividend = '0;
        divisor = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset quotient", quotient, 0);
        check("reset remainder", remainder, 0);
        check("reset dbz", div_by_zero, 0);

        for (int i = 0; i < 8; i++) begin
            run_div(vecs[i].a, vecs[i].b, lat, bn, ok);
            if (ok == 1) begin
                check($sformatf("vec%0d quotient", i), quotient, vecs[i].q);
                check($sformatf("vec%0d remainder", i), remainder, vecs[i].r);
                check($sformatf("vec%0d dbz", i), div_by_zero, vecs[i].dbz);
                check($sformatf("vec%0d latency", i), lat, vecs[i].lat);
                check($sformatf("vec%0d busy cycles", i), bn, vecs[i].busy_cycles);
                @(posedge clk);
                @(negedge clk);
                check($sformatf("vec%0d done one cycle", i), done, 0);
                check($sformatf("vec%0d quotient hold", i), quotient, vecs[i].q);
            end
        end

        // Abort mid-CALC: start 5/7, start again at E2 (ignored), rst at E3.
        @(negedge clk);
        dp = done_pulses;
        start = 1'b1; dividend = 4'd5; divisor = 4'd7;
        @(posedge clk);               // E0
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);               // E1
        @(negedge clk);
        start = 1'b1; dividend = 4'd15; divisor = 4'd1;
        @(posedge clk);               // E2
        @(negedge clk);
        check("abort busy before rst", busy, 1);
        rst = 1'b1;
        @(posedge clk);               // E3
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort quotient", quotient, 0);
        check("abort remainder", remainder, 0);
        check("abort dbz", div_by_zero, 0);
        repeat (6) @(negedge clk);
        check("abort no done pulse", done_pulses, dp);
        run_div(15, 1, lat, bn, ok);
        check("after abort quotient", quotient, 15);
        check("after abort remainder", remainder, 0);

        // Hold start through CALC and DONE: one done pulse, no restart from DONE.
        @(negedge clk);
        dp = done_pulses;
        start = 1'b1; dividend = 4'd14; divisor = 4'd4;
        @(posedge clk);               // E0
        repeat (5) @(posedge clk);    // E1..E5, DONE after E4, IDLE after E5
        @(negedge clk);
        start = 1'b0;
        check("held start done pulses", done_pulses - dp, 1);
        check("held start idle after done", busy, 0);
        check("held start quotient", quotient, 3);
        check("held start remainder", remainder, 2);
        @(posedge clk);               // E6, start now low
        @(negedge clk);
        check("held start no restart", busy, 0);

        // Exhaustive sweep.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                int q, r, good;
                run_div(a, b, lat, bn, ok);
                q = int'(quotient);
                r = int'(remainder);
                if (b == 0)
                    good = (q == 15 && r == a && div_by_zero === 1'b0 ? 0 :
                            q == 15 && r == a && div_by_zero === 1'b1) ? 1 : 0;
                else
                    good = (q * b + r == a && r < b && div_by_zero === 1'b0 && lat == 4) ? 1 : 0;
                total++;
                if (good == 1 && ok == 1) sweep_pass++;
                else begin
                    bad++;
                    $display("FAIL sweep %0d/%0d: got q=%0d r=%0d dbz=%0d lat=%0d", a, b, q, r, div_by_zero, lat);
                end
            end
        end
        check("sweep pass count", sweep_pass, 256);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    final begin
        $display("sweep passing cases: %0d of 256", sweep_pass);
    end

    initial begin
        #2000000;
        $display("FAIL global timeout");
        $fatal(1, "simulation time limit");
    end

endmodule
